// File: rtl/nsa_pkg.sv
// ---------------------------------------------------------------------------
// nsa_pkg
// Shared definitions for the nibble-serial adder: the sequencing FSM state
// encoding and the width of one adder slice.
// ---------------------------------------------------------------------------
package nsa_pkg;

  // Width of the time-shared adder slice
  localparam int NIBBLE_W = 4;

  // Sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage : nsa_pkg

// File: rtl/ripple_carry_adder.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder
// Purely combinational 4-bit ripple-carry adder: {cout,sum} = a + b + cin.
// Ports:
//   a, b  in  4  operands
//   cin   in  1  carry-in
//   sum   out 4  nibble sum
//   cout  out 1  carry-out of bit 3
// ---------------------------------------------------------------------------
module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] w_carry;

  // Carry chain through four full-adder cells
  always_comb begin
    w_carry    = 5'b0_0000;
    sum        = 4'b0000;
    w_carry[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ w_carry[i];
      w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end
    cout = w_carry[4];
  end

endmodule : ripple_carry_adder

// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
// Multi-cycle WIDTH-bit adder that time-shares one 4-bit ripple_carry_adder,
// one nibble per clock, LSB nibble first, with the carry registered between
// cycles. Start/done handshake toward the requester.
// WIDTH must be a multiple of 4 and >= 4.
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, sampled only in IDLE or DONE
//   a, b   in   WIDTH  operands, captured on an accepted start
//   cin    in   1      carry-in to nibble 0, captured on an accepted start
//   busy   out  1      high while nibbles are being processed
//   done   out  1      one-cycle pulse: sum/cout just updated
//   sum    out  WIDTH  result, holds the last completed value
//   cout   out  1      carry out of the MSB nibble, holds last value
// ---------------------------------------------------------------------------
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  // Counter keeps at least one bit so NIB=1 still elaborates
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_r_sh;
  logic               r_c_q;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic [NIBBLE_W-1:0] w_nib_sum;
  logic                w_nib_cout;
  logic [WIDTH-1:0]    w_r_next;

  ripple_carry_adder u_rca (
    .a    (r_a_sh[NIBBLE_W-1:0]),
    .b    (r_b_sh[NIBBLE_W-1:0]),
    .cin  (r_c_q),
    .sum  (w_nib_sum),
    .cout (w_nib_cout)
  );

  // Result shift register next value: new nibble enters at the MSB end.
  // Written as shift-then-overlay so WIDTH=4 needs no empty part-select.
  always_comb begin
    w_r_next = r_r_sh >> NIBBLE_W;
    w_r_next[WIDTH-1 -: NIBBLE_W] = w_nib_sum;
  end

  // Sequencer FSM with operand/result shift registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_r_sh  <= '0;
      r_c_q   <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        // IDLE and DONE both accept a new request; from DONE this gives
        // back-to-back operation without an idle cycle.
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_c_q   <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a_sh <= r_a_sh >> NIBBLE_W;
          r_b_sh <= r_b_sh >> NIBBLE_W;
          r_r_sh <= w_r_next;
          r_c_q  <= w_nib_cout;
          if (r_cnt == CNT_LAST) begin
            // Last nibble: publish the full result straight from the
            // combinational next value rather than waiting a cycle.
            r_sum   <= w_r_next;
            r_cout  <= w_nib_cout;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_busy <= 1'b1;
            r_done <= 1'b0;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule : nibble_serial_adder
